// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: aluop codes,
// FSM state encoding and big-endian byte-lane select constants.
package mem_lsu_pkg;

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_t;

  // Lane 0 (address offset 00) is the most significant byte.
  localparam logic [3:0] SEL_B0   = 4'b1000;
  localparam logic [3:0] SEL_B1   = 4'b0100;
  localparam logic [3:0] SEL_B2   = 4'b0010;
  localparam logic [3:0] SEL_B3   = 4'b0001;
  localparam logic [3:0] SEL_H0   = 4'b1100;
  localparam logic [3:0] SEL_H1   = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;
  localparam logic [3:0] SEL_NONE = 4'b0000;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane select, store replication, load extraction and
// misalignment detection for the load/store unit.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_load,
  output logic        we,
  output logic        misalign,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  byte_lane;
  logic [3:0]  half_lane;

  always_comb begin
    case (addr_lo)
      2'b00:   begin byte_sel = rdata[31:24]; byte_lane = SEL_B0; end
      2'b01:   begin byte_sel = rdata[23:16]; byte_lane = SEL_B1; end
      2'b10:   begin byte_sel = rdata[15:8];  byte_lane = SEL_B2; end
      default: begin byte_sel = rdata[7:0];   byte_lane = SEL_B3; end
    endcase
    half_sel  = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    half_lane = addr_lo[1] ? SEL_H1 : SEL_H0;
  end

  always_comb begin
    is_mem    = 1'b1;
    is_load   = 1'b0;
    we        = 1'b0;
    misalign  = 1'b0;
    sel       = SEL_NONE;
    wdata     = 32'h0;
    load_data = 32'h0;
    case (aluop)
      EXE_LB_OP: begin
        is_load = 1'b1; sel = byte_lane;
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      EXE_LBU_OP: begin
        is_load = 1'b1; sel = byte_lane;
        load_data = {24'h0, byte_sel};
      end
      EXE_LH_OP: begin
        is_load = 1'b1; sel = half_lane; misalign = addr_lo[0];
        load_data = {{16{half_sel[15]}}, half_sel};
      end
      EXE_LHU_OP: begin
        is_load = 1'b1; sel = half_lane; misalign = addr_lo[0];
        load_data = {16'h0, half_sel};
      end
      EXE_LW_OP: begin
        is_load = 1'b1; sel = SEL_WORD; misalign = (addr_lo != 2'b00);
        load_data = rdata;
      end
      EXE_SB_OP: begin
        we = 1'b1; sel = byte_lane; wdata = {4{reg2[7:0]}};
      end
      EXE_SH_OP: begin
        we = 1'b1; sel = half_lane; misalign = addr_lo[0];
        wdata = {2{reg2[15:0]}};
      end
      EXE_SW_OP: begin
        we = 1'b1; sel = SEL_WORD; misalign = (addr_lo != 2'b00);
        wdata = reg2;
      end
      default: is_mem = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack data-bus FSM with timeout, read-data
// capture and write-back field generation toward mem_wb.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mem_aluop,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic        flush,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        misalign,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  lsu_state_t  state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        is_mem;
  logic        is_load;
  logic        op_misalign;
  logic [31:0] load_data;
  logic        start;
  logic        timeout_hit;

  mem_lsu_align u_align (
    .aluop     (mem_aluop),
    .addr_lo   (mem_addr[1:0]),
    .reg2      (mem_reg2),
    .rdata     (rdata_q),
    .is_mem    (is_mem),
    .is_load   (is_load),
    .we        (dbus_we),
    .misalign  (op_misalign),
    .sel       (dbus_sel),
    .wdata     (dbus_wdata),
    .load_data (load_data)
  );

  assign misalign    = is_mem & op_misalign;
  assign start       = is_mem & ~op_misalign & ~flush;
  assign cnt_inc     = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign timeout_hit = (cnt_inc >= TIMEOUT_LIM);
  assign dbus_addr   = {mem_addr[31:2], 2'b00};
  assign bus_err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          err_q <= 1'b0;
          if (start) begin
            state <= ST_BUSY;
            cnt   <= 8'd0;
          end
        end
        ST_BUSY: begin
          cnt <= cnt_inc;
          // Ack beats a same-cycle flush; mem_wb discards the result.
          if (dbus_ack) begin
            rdata_q <= dbus_rdata;
            state   <= ST_DONE;
          end else if (flush) begin
            state <= ST_DRAIN;
          end else if (timeout_hit) begin
            state <= ST_DONE;
            err_q <= 1'b1;
          end
        end
        ST_DONE: begin
          err_q <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          cnt <= cnt_inc;
          if (dbus_ack || timeout_hit) state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wb_wd    = mem_wd;
    wb_wreg  = 1'b0;
    wb_wdata = mem_wdata;
    dbus_req = 1'b0;
    stallreq = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!is_mem || flush) begin
          wb_wreg = mem_wreg;
        end else if (!op_misalign) begin
          dbus_req = 1'b1;
          stallreq = 1'b1;
        end
      end
      ST_DONE: begin
        if (is_load && !err_q) begin
          wb_wreg  = mem_wreg;
          wb_wdata = load_data;
        end
      end
      default: begin
        dbus_req = 1'b1;
        stallreq = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: two instances (default timeout and a short
// timeout) share stimulus; expected values are hand-derived constants.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  mem_aluop;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_reg2;
  logic        flush;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  logic [4:0]  wb_wd,    wb_wd4;
  logic        wb_wreg,  wb_wreg4;
  logic [31:0] wb_wdata, wb_wdata4;
  logic        stallreq, stallreq4;
  logic        misalign, misalign4;
  logic        bus_err,  bus_err4;
  logic        dbus_req, dbus_req4;
  logic        dbus_we,  dbus_we4;
  logic [31:0] dbus_addr, dbus_addr4;
  logic [3:0]  dbus_sel, dbus_sel4;
  logic [31:0] dbus_wdata, dbus_wdata4;

  int tests;
  int failed;

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n), .mem_aluop(mem_aluop), .mem_wd(mem_wd),
    .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_reg2(mem_reg2), .flush(flush), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .stallreq(stallreq), .misalign(misalign),
    .bus_err(bus_err), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  mem_lsu #(.TIMEOUT_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mem_aluop(mem_aluop), .mem_wd(mem_wd),
    .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_reg2(mem_reg2), .flush(flush), .wb_wd(wb_wd4), .wb_wreg(wb_wreg4),
    .wb_wdata(wb_wdata4), .stallreq(stallreq4), .misalign(misalign4),
    .bus_err(bus_err4), .dbus_req(dbus_req4), .dbus_we(dbus_we4),
    .dbus_addr(dbus_addr4), .dbus_sel(dbus_sel4), .dbus_wdata(dbus_wdata4),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [4:0] wd,
                          input logic wreg, input logic [31:0] wdata);
    mem_aluop = op;
    mem_addr  = addr;
    mem_reg2  = reg2;
    mem_wd    = wd;
    mem_wreg  = wreg;
    mem_wdata = wdata;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    drive_op(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #12;
    check("rst_req", {31'h0, dbus_req}, 32'd0);
    check("rst_stall", {31'h0, stallreq}, 32'd0);
    check("rst_wreg", {31'h0, wb_wreg}, 32'd0);
    check("rst_buserr", {31'h0, bus_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // SW, ack on 2nd BUSY cycle
    drive_op(EXE_SW_OP, 32'h100, 32'hDEADBEEF, 5'd9, 1'b1, 32'h0);
    #1;
    check("sw_req", {31'h0, dbus_req}, 32'd1);
    check("sw_we", {31'h0, dbus_we}, 32'd1);
    check("sw_sel", {28'h0, dbus_sel}, 32'hF);
    check("sw_wdata", dbus_wdata, 32'hDEADBEEF);
    check("sw_addr", dbus_addr, 32'h100);
    check("sw_stall0", {31'h0, stallreq}, 32'd1);
    tick();
    check("sw_stall1", {31'h0, stallreq}, 32'd1);
    check("sw_req1", {31'h0, dbus_req}, 32'd1);
    tick();
    check("sw_stall2", {31'h0, stallreq}, 32'd1);
    dbus_ack = 1'b1;
    tick();
    dbus_ack = 1'b0;
    check("sw_done_stall", {31'h0, stallreq}, 32'd0);
    check("sw_done_req", {31'h0, dbus_req}, 32'd0);
    check("sw_done_wreg", {31'h0, wb_wreg}, 32'd0);
    tick();

    // LB then LBU at 0x103, ack on 1st BUSY cycle
    for (int k = 0; k < 2; k++) begin
      drive_op((k == 0) ? EXE_LB_OP : EXE_LBU_OP, 32'h103, 32'h0, 5'd5, 1'b1, 32'h0);
      #1;
      check("lb_sel", {28'h0, dbus_sel}, 32'h1);
      check("lb_we", {31'h0, dbus_we}, 32'd0);
      check("lb_addr", dbus_addr, 32'h100);
      tick();
      dbus_ack = 1'b1;
      dbus_rdata = 32'h000000F0;
      tick();
      dbus_ack = 1'b0;
      dbus_rdata = 32'h0;
      #1;
      check("lb_wd", {27'h0, wb_wd}, 32'd5);
      check("lb_wreg", {31'h0, wb_wreg}, 32'd1);
      check("lb_wdata", wb_wdata, (k == 0) ? 32'hFFFFFFF0 : 32'h000000F0);
      check("lb_stall", {31'h0, stallreq}, 32'd0);
      tick();
    end

    // Misaligned LH
    drive_op(EXE_LH_OP, 32'h101, 32'h0, 5'd6, 1'b1, 32'h0);
    #1;
    check("mis_flag", {31'h0, misalign}, 32'd1);
    check("mis_req", {31'h0, dbus_req}, 32'd0);
    check("mis_stall", {31'h0, stallreq}, 32'd0);
    check("mis_wreg", {31'h0, wb_wreg}, 32'd0);
    tick();
    check("mis_req_after", {31'h0, dbus_req}, 32'd0);

    // Aligned LH at 0x102: lower half, sign extended from captured data
    drive_op(EXE_LH_OP, 32'h102, 32'h0, 5'd7, 1'b1, 32'h0);
    #1;
    check("lh_mis", {31'h0, misalign}, 32'd0);
    check("lh_sel", {28'h0, dbus_sel}, 32'h3);
    tick();
    dbus_ack = 1'b1;
    dbus_rdata = 32'h12348001;
    tick();
    dbus_ack = 1'b0;
    check("lh_wdata", wb_wdata, 32'hFFFF8001);
    tick();

    // SB replication
    drive_op(EXE_SB_OP, 32'h201, 32'h000000A5, 5'd0, 1'b0, 32'h0);
    #1;
    check("sb_sel", {28'h0, dbus_sel}, 32'h4);
    check("sb_wdata", dbus_wdata, 32'hA5A5A5A5);
    drive_op(EXE_SH_OP, 32'h202, 32'h0000BEEF, 5'd0, 1'b0, 32'h0);
    #1;
    check("sh_sel", {28'h0, dbus_sel}, 32'h3);
    check("sh_wdata", dbus_wdata, 32'hBEEFBEEF);

    // Flush in BUSY, ack arrives later in DRAIN
    drive_op(EXE_LW_OP, 32'h200, 32'h0, 5'd8, 1'b1, 32'h0);
    tick();
    flush = 1'b1;
    check("fl_busy_req", {31'h0, dbus_req}, 32'd1);
    tick();
    flush = 1'b0;
    for (int d = 0; d < 3; d++) begin
      #1;
      check("fl_drain_req", {31'h0, dbus_req}, 32'd1);
      check("fl_drain_stall", {31'h0, stallreq}, 32'd1);
      check("fl_drain_wreg", {31'h0, wb_wreg}, 32'd0);
      if (d == 2) begin
        dbus_ack = 1'b1;
        dbus_rdata = 32'hCAFEF00D;
      end
      tick();
    end
    dbus_ack = 1'b0;
    drive_op(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    check("fl_idle_stall", {31'h0, stallreq}, 32'd0);
    check("fl_idle_req", {31'h0, dbus_req}, 32'd0);
    check("fl_buserr", {31'h0, bus_err}, 32'd0);

    // Timeout on the TIMEOUT_CYC=4 instance; no ack ever arrives
    drive_op(EXE_LW_OP, 32'h300, 32'h0, 5'd4, 1'b1, 32'h0);
    #1;
    check("to_req_idle", {31'h0, dbus_req4}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      tick();
      check("to_busy_req", {31'h0, dbus_req4}, 32'd1);
      check("to_busy_err", {31'h0, bus_err4}, 32'd0);
    end
    tick();
    check("to_done_err", {31'h0, bus_err4}, 32'd1);
    check("to_done_wreg", {31'h0, wb_wreg4}, 32'd0);
    check("to_done_req", {31'h0, dbus_req4}, 32'd0);
    check("to_done_stall", {31'h0, stallreq4}, 32'd0);
    tick();
    drive_op(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    check("to_idle_err", {31'h0, bus_err4}, 32'd0);

    // Default instance is still waiting in BUSY; reset drops it at once
    check("rs_busy_req", {31'h0, dbus_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_req", {31'h0, dbus_req}, 32'd0);
    check("rs_stall", {31'h0, stallreq}, 32'd0);
    #10;
    rst_n = 1'b1;
    drive_op(EXE_ADD_OP, 32'h0, 32'h0, 5'd3, 1'b1, 32'd7);
    #1;
    check("add_wdata", wb_wdata, 32'd7);
    check("add_wd", {27'h0, wb_wd}, 32'd3);
    check("add_wreg", {31'h0, wb_wreg}, 32'd1);
    check("add_stall", {31'h0, stallreq}, 32'd0);
    check("add_req", {31'h0, dbus_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit. It is the consumer end of the EX/MEM pipeline register.
- Takes mem_aluop, mem_wd, mem_wreg and mem_wdata plus the effective address and store data latched by EX/MEM.
- Runs a req/ack transaction on the data bus.
- Raises stallreq to ctrl until the access completes, then presents write-back fields to mem_wb.
- Non-memory ops pass straight through with zero added latency.

Parameters:
- TIMEOUT_CYC, 255: maximum BUSY/DRAIN cycles without dbus_ack before the transaction is aborted; legal range 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_aluop  in  8 (`AluOpBus)  op from EX/MEM
- mem_wd  in  5 (`RegAddrBus)  destination register
- mem_wreg  in  1  write enable from EX/MEM
- mem_wdata  in  32 (`RegBus)  ALU result, forwarded for non-memory ops
- mem_addr  in  32  effective address
- mem_reg2  in  32  store source data
- flush  in  1  pipeline flush from ctrl
- wb_wd  out  5  destination register to mem_wb
- wb_wreg  out  1  write enable to mem_wb
- wb_wdata  out  32  write-back data
- stallreq  out  1  stall request to ctrl
- misalign  out  1  misaligned-access flag, combinational
- bus_err  out  1  one-cycle pulse on timeout
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = store
- dbus_addr  out  32  word address, low 2 bits forced to 0
- dbus_sel  out  4  byte-lane enables
- dbus_wdata  out  32  store data, lane-replicated
- dbus_ack  in  1  completion, sampled only in BUSY/DRAIN
- dbus_rdata  in  32  read data, valid with ack

Behaviour:
- Reset (rst_n=0, async): state IDLE, timeout counter 0, captured rdata 0, bus_err 0.
  - Combinational outputs then evaluate to dbus_req=0, stallreq=0, wb_wreg=0.
  - Reset mid-transaction abandons the bus request immediately.
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW (`EXE_*_OP). Every other aluop is a non-memory op.
- Byte lanes are big-endian.
  - addr[1:0]=00 selects lane 4'b1000, 01 selects 4'b0100, 10 selects 4'b0010, 11 selects 4'b0001.
  - Halfword at addr[1]=0 selects 4'b1100, else 4'b0011.
  - Word selects 4'b1111.
- Store data replication: SB drives {4{reg2[7:0]}}, SH drives {2{reg2[15:0]}}, SW drives reg2.
- Load extraction: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
- Misaligned accesses: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Response: misalign=1, no request, stallreq=0, wb_wreg=0, completes in 0 cycles.
- Non-memory op, or flush=1 while in IDLE: wb_* = mem_* combinationally, stallreq=0, dbus_req=0.
- FSM states: IDLE, BUSY, DONE, DRAIN.
- IDLE, aligned memory op present, no flush:
  - Drive dbus_req=1 with addr/sel/we/wdata; stallreq=1.
  - Next edge goes to BUSY and clears the counter.
- BUSY:
  - dbus_req=1 held, stallreq=1, counter increments.
  - dbus_ack=1: capture rdata, go to DONE.
  - flush=1 without ack: go to DRAIN.
  - Counter reaches TIMEOUT_CYC: go to DONE, set error flag, pulse bus_err for that DONE cycle.
  - ack and flush in the same cycle: ack wins, then DONE; the flush is applied by mem_wb.
- DONE:
  - dbus_req=0, stallreq=0.
  - Load: wb_wreg=mem_wreg, wb_wdata=extracted data.
  - Store: wb_wreg=0.
  - Timeout: wb_wreg=0.
  - Next edge returns to IDLE, since the pipeline advances.
- DRAIN:
  - dbus_req=1, stallreq=1, result discarded, wb_wreg=0.
  - On ack or timeout: go to IDLE, with no bus_err on a DRAIN timeout.
- Minimum load latency: 3 cycles (IDLE req, BUSY with ack, DONE).
- dbus_ack outside BUSY/DRAIN is ignored.
- Counter width is 8 bits and saturates; it never wraps.

Decomposition:
- Shared defines: aluop codes (existing), FSM state encoding, and byte-lane select constants.
- Sub-module mem_lsu_align: combinational sel/wdata generation, load extraction and misalign detect.
- mem_lsu keeps the FSM, counter and capture register.

Test Plan:
- SW addr=0x100, reg2=0xDEADBEEF, ack on 2nd BUSY cycle:
  - dbus_we=1, sel=4'b1111, wdata=0xDEADBEEF.
  - stallreq high for 3 cycles, wb_wreg=0 in DONE.
- LB addr=0x103, rdata=0x000000F0, mem_wd=5, mem_wreg=1, ack on 1st BUSY cycle:
  - sel=4'b0001, DONE shows wb_wd=5, wb_wreg=1, wb_wdata=0xFFFFFFF0.
  - Same access with LBU gives wb_wdata=0x000000F0.
- LH addr=0x101:
  - misalign=1, dbus_req stays 0, stallreq=0, wb_wreg=0.
- Flush in BUSY, ack 4 cycles later:
  - DRAIN holds dbus_req=1 and stallreq=1, then IDLE.
  - No write-back, bus_err=0.
- TIMEOUT_CYC=4, no ack:
  - Request held 4 BUSY cycles, then DONE with bus_err=1 for 1 cycle and wb_wreg=0.
- rst_n low while in BUSY:
  - dbus_req=0 and stallreq=0 immediately, without waiting for a clock edge.
  - After release, an ADD with mem_wdata=7 passes through with zero latency.
